// File: rtl/full_adder.sv
// Ripple-carry adder built from chained 1-bit full-adder cells, with a
// combinational sum/carry/overflow path and an enable-captured registered copy.

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic             en,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             ovf_q,
  output logic             valid_q
);

  // carry[i] is the carry into bit i; carry[WIDTH] is the carry-out
  logic [WIDTH:0] carry;

  assign carry[0] = c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  assign cout = carry[WIDTH];
  // Signed overflow: carry into the MSB disagrees with carry out of it
  assign ovf  = carry[WIDTH-1] ^ carry[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= en;
      if (en) begin
        sum_q  <= sum;
        cout_q <= cout;
        ovf_q  <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: a 1-bit and an 8-bit instance, with
// registered-path expectations queued at drive time and popped after the edge.

module tb_full_adder;

  logic       clk = 1'b0;
  int         errors = 0;
  int         checks = 0;

  // 1-bit instance
  logic       rst1, a1, b1, c1, en1;
  logic       sum1, cout1, ovf1, sum1_q, cout1_q, ovf1_q, valid1_q;

  // 8-bit instance
  logic       rst8, c8, en8;
  logic [7:0] a8, b8, sum8, sum8_q;
  logic       cout8, ovf8, cout8_q, ovf8_q, valid8_q;

  // {valid, ovf, cout, sum}
  logic [3:0]  sb1[$];
  logic [10:0] sb8[$];

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst1), .a(a1), .b(b1), .c(c1), .en(en1),
    .sum(sum1), .cout(cout1), .ovf(ovf1),
    .sum_q(sum1_q), .cout_q(cout1_q), .ovf_q(ovf1_q), .valid_q(valid1_q)
  );

  full_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst8), .a(a8), .b(b8), .c(c8), .en(en8),
    .sum(sum8), .cout(cout8), .ovf(ovf8),
    .sum_q(sum8_q), .cout_q(cout8_q), .ovf_q(ovf8_q), .valid_q(valid8_q)
  );

  task automatic test_comb_exhaustive;
    logic [1:0] exp_tab [8];
    exp_tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    en1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      {a1, b1, c1} = v;
      #5;
      checks++;
      if ({cout1, sum1} !== exp_tab[i]) begin
        errors++;
        $display("FAIL comb1 abc=%0d got cout,sum=%b required %b", i, {cout1, sum1}, exp_tab[i]);
      end
      checks++;
      if (ovf1 !== (c1 ^ exp_tab[i][1])) begin
        errors++;
        $display("FAIL comb1_ovf abc=%0d got %b required %b", i, ovf1, c1 ^ exp_tab[i][1]);
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst1 = 1'b1; rst8 = 1'b1; en1 = 1'b1; en8 = 1'b1;
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({valid1_q, ovf1_q, cout1_q, sum1_q} !== 4'b0000) begin
      errors++;
      $display("FAIL reset1_regs got %b required 0000", {valid1_q, ovf1_q, cout1_q, sum1_q});
    end
    checks++;
    if ({valid8_q, ovf8_q, cout8_q, sum8_q} !== 11'd0) begin
      errors++;
      $display("FAIL reset8_regs got %h required 000", {valid8_q, ovf8_q, cout8_q, sum8_q});
    end
    checks++;
    if ({cout1, sum1} !== 2'b11) begin
      errors++;
      $display("FAIL reset1_comb_live got %b required 11", {cout1, sum1});
    end
    checks++;
    if ({cout8, sum8} !== 9'h1FF) begin
      errors++;
      $display("FAIL reset8_comb_live got %h required 1ff", {cout8, sum8});
    end
  endtask

  task automatic test_capture_hold;
    logic [3:0] exp_r;
    @(negedge clk);
    rst1 = 1'b0; rst8 = 1'b0;
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b0; en1 = 1'b1;
    sb1.push_back(4'b1110);       // valid=1 ovf=1 cout=1 sum=0
    @(posedge clk); #1;
    exp_r = (sb1.size() > 0) ? sb1.pop_front() : 4'bxxxx;
    checks++;
    if ({valid1_q, ovf1_q, cout1_q, sum1_q} !== exp_r) begin
      errors++;
      $display("FAIL capture1 got %b required %b", {valid1_q, ovf1_q, cout1_q, sum1_q}, exp_r);
    end
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b0; c1 = 1'b0; en1 = 1'b0;
    sb1.push_back(4'b0110);       // held values, valid drops
    @(posedge clk); #1;
    exp_r = (sb1.size() > 0) ? sb1.pop_front() : 4'bxxxx;
    checks++;
    if ({valid1_q, ovf1_q, cout1_q, sum1_q} !== exp_r) begin
      errors++;
      $display("FAIL hold1 got %b required %b", {valid1_q, ovf1_q, cout1_q, sum1_q}, exp_r);
    end
  endtask

  task automatic test_wide_comb;
    logic [7:0] ta [4];
    logic [7:0] tb [4];
    logic       tc [4];
    logic [9:0] te [4];    // {ovf, cout, sum}
    ta = '{8'hFF, 8'h7F, 8'hFF, 8'h00};
    tb = '{8'h00, 8'h01, 8'hFF, 8'h00};
    tc = '{1'b1,  1'b0,  1'b1,  1'b0};
    te = '{10'b0_1_00000000, 10'b1_0_10000000, 10'b0_1_11111111, 10'b0_0_00000000};
    en8 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a8 = ta[i]; b8 = tb[i]; c8 = tc[i];
      #5;
      checks++;
      if ({ovf8, cout8, sum8} !== te[i]) begin
        errors++;
        $display("FAIL wide_comb%0d got ovf,cout,sum=%b required %b", i, {ovf8, cout8, sum8}, te[i]);
      end
    end
  endtask

  task automatic test_reset_priority;
    logic [10:0] exp_r;
    @(negedge clk);
    rst8 = 1'b0; en8 = 1'b1;
    a8 = 8'h80; b8 = 8'h80; c8 = 1'b0;
    sb8.push_back({1'b1, 1'b1, 1'b1, 8'h00});
    @(posedge clk); #1;
    exp_r = (sb8.size() > 0) ? sb8.pop_front() : 'x;
    checks++;
    if ({valid8_q, ovf8_q, cout8_q, sum8_q} !== exp_r) begin
      errors++;
      $display("FAIL capture8 got %h required %h", {valid8_q, ovf8_q, cout8_q, sum8_q}, exp_r);
    end
    @(negedge clk);
    rst8 = 1'b1; en8 = 1'b1;
    a8 = 8'h12; b8 = 8'h34; c8 = 1'b1;
    sb8.push_back(11'd0);
    @(posedge clk); #1;
    exp_r = (sb8.size() > 0) ? sb8.pop_front() : 'x;
    checks++;
    if ({valid8_q, ovf8_q, cout8_q, sum8_q} !== exp_r) begin
      errors++;
      $display("FAIL reset_wins8 got %h required %h", {valid8_q, ovf8_q, cout8_q, sum8_q}, exp_r);
    end
    checks++;
    if ({cout8, sum8} !== 9'h047) begin
      errors++;
      $display("FAIL reset_comb8 got %h required 047", {cout8, sum8});
    end
    @(negedge clk);
    rst8 = 1'b0;
  endtask

  task automatic test_random;
    logic [7:0]  ra, rb;
    logic        rc, ren, rovf;
    logic [8:0]  ref9;
    logic [9:0]  hold;
    logic [10:0] exp_r;
    hold = '0;
    for (int i = 0; i < 1000; i++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rc  = 1'($urandom);
      ren = (i == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      @(negedge clk);
      a8 = ra; b8 = rb; c8 = rc; en8 = ren;
      #1;
      ref9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      rovf = (ra[7] == rb[7]) && (ref9[7] != ra[7]);
      checks++;
      if ({ovf8, cout8, sum8} !== {rovf, ref9}) begin
        errors++;
        $display("FAIL rand_comb a=%h b=%h c=%b got %h required %h", ra, rb, rc, {ovf8, cout8, sum8}, {rovf, ref9});
      end
      if (ren) hold = {rovf, ref9};
      sb8.push_back({ren, hold});
      @(posedge clk); #1;
      exp_r = (sb8.size() > 0) ? sb8.pop_front() : 'x;
      checks++;
      if ({valid8_q, ovf8_q, cout8_q, sum8_q} !== exp_r) begin
        errors++;
        $display("FAIL rand_reg vec=%0d got %h required %h", i, {valid8_q, ovf8_q, cout8_q, sum8_q}, exp_r);
      end
    end
  endtask

  initial begin
    rst1 = 1'b0; rst8 = 1'b0; en1 = 1'b0; en8 = 1'b0;
    a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
    test_comb_exhaustive();
    test_reset();
    test_capture_hold();
    test_wide_comb();
    test_reset_priority();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
